// File: rtl/circular_dma_pkg.sv
// Shared types and constants for the circular DMA stream arbiter.
package circular_dma_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_HEADER, ST_DATA} arb_state_t;

  localparam logic [7:0] HDR_MAGIC = 8'hA5;

endpackage

// File: rtl/circular_dma_rr_select.sv
// Round-robin search: first requesting index strictly after `last`, modulo N.
module circular_dma_rr_select #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic                 found,
  output logic [$clog2(N)-1:0] next
);

  localparam int IW = $clog2(N);

  always_comb begin : search
    logic [IW-1:0] cand;
    cand  = '0;
    found = 1'b0;
    next  = '0;
    // Offset 1..N puts `last` itself at the very end of the search order.
    for (int i = 1; i <= N; i++) begin
      cand = IW'((int'(last) + i) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        next  = cand;
      end
    end
  end

endmodule

// File: rtl/circular_dma_stream_arbiter.sv
// Packet-granular round-robin arbiter feeding the circular DMA S2MM stream,
// optionally prefixing each packet with a header beat carrying the source index.
module circular_dma_stream_arbiter
  import circular_dma_pkg::*;
#(
  parameter int C_NUM_SOURCES = 4,
  parameter int C_AXIS_WIDTH  = 64,
  parameter int C_HEADER      = 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  enable,
  input  logic [C_NUM_SOURCES*C_AXIS_WIDTH-1:0] s_axis_tdata,
  input  logic [C_NUM_SOURCES-1:0]              s_axis_tlast,
  input  logic [C_NUM_SOURCES-1:0]              s_axis_tvalid,
  output logic [C_NUM_SOURCES-1:0]              s_axis_tready,
  output logic [C_AXIS_WIDTH-1:0]               m_axis_tdata,
  output logic                                  m_axis_tlast,
  output logic                                  m_axis_tvalid,
  input  logic                                  m_axis_tready,
  output logic                                  busy,
  output logic [$clog2(C_NUM_SOURCES)-1:0]      grant_idx,
  output logic [31:0]                           pkt_count
);

  localparam int IW = $clog2(C_NUM_SOURCES);

  arb_state_t    state;
  logic [IW-1:0] last;
  logic          found;
  logic [IW-1:0] next_idx;
  logic          last_beat;

  circular_dma_rr_select #(.N(C_NUM_SOURCES)) u_rr_select (
    .req   (s_axis_tvalid),
    .last  (last),
    .found (found),
    .next  (next_idx)
  );

  assign last_beat = s_axis_tvalid[grant_idx] & m_axis_tready & s_axis_tlast[grant_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      last      <= IW'(C_NUM_SOURCES - 1);
      grant_idx <= '0;
      pkt_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable && found) begin
            grant_idx <= next_idx;
            last      <= next_idx;
            state     <= (C_HEADER != 0) ? ST_HEADER : ST_DATA;
          end
        end
        ST_HEADER: begin
          if (m_axis_tready) state <= ST_DATA;
        end
        ST_DATA: begin
          if (last_beat) begin
            pkt_count <= pkt_count + 32'd1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode directly from registered state so an async reset clears them at once.
  always_comb begin
    s_axis_tready = '0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tvalid = 1'b0;
    case (state)
      ST_HEADER: begin
        m_axis_tvalid          = 1'b1;
        m_axis_tdata[15:8]     = HDR_MAGIC;
        m_axis_tdata[IW-1:0]   = grant_idx;
      end
      ST_DATA: begin
        m_axis_tdata             = s_axis_tdata[int'(grant_idx)*C_AXIS_WIDTH +: C_AXIS_WIDTH];
        m_axis_tlast             = s_axis_tlast[grant_idx];
        m_axis_tvalid            = s_axis_tvalid[grant_idx];
        s_axis_tready[grant_idx] = m_axis_tready;
      end
      default: ;
    endcase
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_circular_dma_stream_arbiter.sv
// Directed bench for the circular DMA stream arbiter (header and no-header builds).
module tb_circular_dma_stream_arbiter;

  localparam int N = 4;
  localparam int W = 64;

  logic           clk;
  logic           rst_n;
  logic           enable;
  logic [N*W-1:0] s_tdata;
  logic [N-1:0]   s_tlast;
  logic [N-1:0]   s_tvalid;
  logic           m_tready;

  logic [N-1:0]   s_tready;
  logic [W-1:0]   m_tdata;
  logic           m_tlast;
  logic           m_tvalid;
  logic           busy;
  logic [1:0]     grant_idx;
  logic [31:0]    pkt_count;

  logic [N-1:0]   s0_tready;
  logic [W-1:0]   m0_tdata;
  logic           m0_tlast;
  logic           m0_tvalid;
  logic           busy0;
  logic [1:0]     grant0;
  logic [31:0]    pkt0;

  circular_dma_stream_arbiter #(.C_NUM_SOURCES(N), .C_AXIS_WIDTH(W), .C_HEADER(1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .busy(busy), .grant_idx(grant_idx), .pkt_count(pkt_count)
  );

  circular_dma_stream_arbiter #(.C_NUM_SOURCES(N), .C_AXIS_WIDTH(W), .C_HEADER(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s0_tready),
    .m_axis_tdata(m0_tdata), .m_axis_tlast(m0_tlast), .m_axis_tvalid(m0_tvalid),
    .m_axis_tready(m_tready),
    .busy(busy0), .grant_idx(grant0), .pkt_count(pkt0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  int len [N];
  int npkt[N];
  int beat[N];
  int cyc;
  bit bp;
  int rdy_cnt[N];
  int rdy_bad;

  logic [W-1:0] log_d[$];
  logic         log_l[$];
  int           log_c[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] dval(input int s, input int b);
    return 64'hC0DE_0000_0000_0000 + 64'(s) * 64'd256 + 64'(b);
  endfunction

  task automatic drive_sources();
    for (int i = 0; i < N; i++) begin
      s_tvalid[i]       = (npkt[i] > 0);
      s_tlast[i]        = (beat[i] == len[i] - 1);
      s_tdata[i*W +: W] = dval(i, beat[i]);
    end
  endtask

  // Sample at the current mid-cycle point, advance one clock, then drive new inputs.
  task automatic cycle();
    logic [N-1:0] hs;
    hs = s_tvalid & s_tready;
    if (m_tvalid && m_tready) begin
      log_d.push_back(m_tdata);
      log_l.push_back(m_tlast);
      log_c.push_back(cyc);
    end
    for (int i = 0; i < N; i++) if (s_tready[i]) rdy_cnt[i]++;
    if ((s_tready != '0) && !m_tready) rdy_bad++;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        if (beat[i] == len[i] - 1) begin
          beat[i] = 0;
          npkt[i]--;
        end else begin
          beat[i]++;
        end
      end
    end
    m_tready = bp ? (cyc % 2 == 0) : 1'b1;
    drive_sources();
    #1;
  endtask

  task automatic start_test();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      len[i] = 1; npkt[i] = 0; beat[i] = 0; rdy_cnt[i] = 0;
    end
    rdy_bad  = 0;
    bp       = 1'b0;
    m_tready = 1'b1;
    enable   = 1'b1;
    drive_sources();
    log_d.delete(); log_l.delete(); log_c.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic run_until_pkt(input string tag, input int n, input int max);
    int k;
    k = 0;
    while (pkt_count != 32'(n) && k < max) begin
      cycle();
      k++;
    end
    chk(tag, 64'(pkt_count), 64'(n));
  endtask

  logic [W-1:0] e1[4];
  logic [W-1:0] e2[12];
  logic [W-1:0] e3[5];

  initial begin
    e1 = '{64'h0000_0000_0000_A502, 64'hC0DE_0000_0000_0200,
           64'hC0DE_0000_0000_0201, 64'hC0DE_0000_0000_0202};
    e2 = '{64'h0000_0000_0000_A500, 64'hC0DE_0000_0000_0000, 64'hC0DE_0000_0000_0001,
           64'h0000_0000_0000_A501, 64'hC0DE_0000_0000_0100, 64'hC0DE_0000_0000_0101,
           64'h0000_0000_0000_A502, 64'hC0DE_0000_0000_0200, 64'hC0DE_0000_0000_0201,
           64'h0000_0000_0000_A503, 64'hC0DE_0000_0000_0300, 64'hC0DE_0000_0000_0301};
    e3 = '{64'h0000_0000_0000_A501, 64'hC0DE_0000_0000_0100, 64'hC0DE_0000_0000_0101,
           64'hC0DE_0000_0000_0102, 64'hC0DE_0000_0000_0103};

    // Reset state, with a requester present to show nothing leaks through.
    rst_n    = 1'b0;
    enable   = 1'b1;
    m_tready = 1'b1;
    s_tvalid = 4'b1111;
    s_tlast  = 4'b1111;
    s_tdata  = {N*W{1'b1}};
    #12;
    chk("rst_tready",  64'(s_tready),  64'h0);
    chk("rst_tvalid",  64'(m_tvalid),  64'h0);
    chk("rst_tlast",   64'(m_tlast),   64'h0);
    chk("rst_tdata",   m_tdata,        64'h0);
    chk("rst_busy",    64'(busy),      64'h0);
    chk("rst_grant",   64'(grant_idx), 64'h0);
    chk("rst_pkt",     64'(pkt_count), 64'h0);
    chk("rst0_tvalid", 64'(m0_tvalid), 64'h0);

    // Single source 2, three beats.
    start_test();
    len[2] = 3; npkt[2] = 1;
    drive_sources();
    #1;
    run_until_pkt("t1_pkt", 1, 20);
    cycle();
    chk("t1_nbeats", 64'(log_d.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < log_d.size()) begin
        chk("t1_data", log_d[i], e1[i]);
        chk("t1_last", 64'(log_l[i]), (i == 3) ? 64'd1 : 64'd0);
      end
    end
    if (log_c.size() > 0) chk("t1_hdr_latency", 64'(log_c[0]), 64'd1);
    chk("t1_rdy2", 64'(rdy_cnt[2]), 64'd3);
    chk("t1_rdy_other", 64'(rdy_cnt[0] + rdy_cnt[1] + rdy_cnt[3]), 64'd0);
    chk("t1_grant", 64'(grant_idx), 64'd2);
    chk("t1_busy", 64'(busy), 64'd0);

    // All four sources contend with two-beat packets.
    start_test();
    for (int i = 0; i < N; i++) begin
      len[i] = 2; npkt[i] = 1;
    end
    drive_sources();
    #1;
    run_until_pkt("t2_pkt", 4, 40);
    chk("t2_nbeats", 64'(log_d.size()), 64'd12);
    for (int i = 0; i < 12; i++) begin
      if (i < log_d.size()) begin
        chk("t2_data", log_d[i], e2[i]);
        chk("t2_last", 64'(log_l[i]), (i % 3 == 2) ? 64'd1 : 64'd0);
        if (i % 3 == 0) chk("t2_hdr_cycle", 64'(log_c[i]), 64'(1 + 4 * (i / 3)));
      end
    end

    // Output backpressure toggling each cycle on a four-beat packet from source 1.
    start_test();
    len[1] = 4; npkt[1] = 1; bp = 1'b1;
    drive_sources();
    #1;
    run_until_pkt("t3_pkt", 1, 40);
    chk("t3_nbeats", 64'(log_d.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < log_d.size()) chk("t3_data", log_d[i], e3[i]);
    end
    chk("t3_rdy1", 64'(rdy_cnt[1]), 64'd4);
    chk("t3_rdy_without_mready", 64'(rdy_bad), 64'd0);

    // Enable drops after beat 1; source 3 waits until enable returns.
    start_test();
    len[0] = 4; npkt[0] = 1;
    len[3] = 1; npkt[3] = 1;
    drive_sources();
    #1;
    for (int i = 0; i < 4; i++) cycle();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    chk("t4_pkt_done", 64'(pkt_count), 64'd1);
    chk("t4_busy_low", 64'(busy), 64'd0);
    chk("t4_no_grant", 64'(grant_idx), 64'd0);
    chk("t4_idle_tvalid", 64'(m_tvalid), 64'd0);
    chk("t4_nbeats", 64'(log_d.size()), 64'd5);
    if (log_l.size() == 5) chk("t4_last", 64'(log_l[4]), 64'd1);
    enable = 1'b1;
    run_until_pkt("t4_pkt_after", 2, 20);
    chk("t4_grant3", 64'(grant_idx), 64'd3);
    if (log_d.size() > 5) chk("t4_hdr3", log_d[5], 64'h0000_0000_0000_A503);

    // Asynchronous reset in the middle of a DATA phase.
    start_test();
    len[2] = 4; npkt[2] = 1;
    drive_sources();
    #1;
    for (int i = 0; i < 3; i++) cycle();
    chk("t5_busy_pre", 64'(busy), 64'd1);
    chk("t5_rdy_pre", 64'(s_tready), 64'b0100);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_tready", 64'(s_tready), 64'h0);
    chk("t5_tvalid", 64'(m_tvalid), 64'h0);
    chk("t5_busy",   64'(busy),     64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) beat[i] = 0;
    len[0] = 1; npkt[0] = 1; npkt[2] = 1;
    log_d.delete(); log_l.delete(); log_c.delete();
    cyc = 0;
    drive_sources();
    #1;
    cycle();
    cycle();
    chk("t5_grant0", 64'(grant_idx), 64'd0);
    if (log_d.size() > 0) chk("t5_hdr0", log_d[0], 64'h0000_0000_0000_A500);
    else chk("t5_hdr_seen", 64'(log_d.size()), 64'd1);

    // Header-less build: one-beat packet from source 1.
    start_test();
    #1;
    s_tvalid        = 4'b0010;
    s_tlast         = 4'b0010;
    s_tdata[W +: W] = 64'h1234_5678_9ABC_DEF0;
    #1;
    chk("t6_idle_tvalid", 64'(m0_tvalid), 64'd0);
    @(posedge clk);
    #2;
    chk("t6_tvalid", 64'(m0_tvalid), 64'd1);
    chk("t6_tdata",  m0_tdata,       64'h1234_5678_9ABC_DEF0);
    chk("t6_tlast",  64'(m0_tlast),  64'd1);
    chk("t6_tready", 64'(s0_tready), 64'b0010);
    chk("t6_grant",  64'(grant0),    64'd1);
    @(posedge clk);
    #1;
    s_tvalid = 4'b0000;
    #1;
    chk("t6_pkt",    64'(pkt0),      64'd1);
    chk("t6_busy",   64'(busy0),     64'd0);
    chk("t6_after",  64'(m0_tvalid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
